// File: rtl/req_ack_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : req_ack_accumulator
// Purpose  : Sums FrameLength words received over REQ/ACK into one frame
//            total and presents it over REQ/ACK. Optional frame counter is
//            enabled by defining REQ_ACK_ACC_FRAMECNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module req_ack_accumulator #(
   parameter int  bit_width   = 5,
   parameter int  FrameLength = 4,
   localparam int AccWidth    = bit_width + $clog2(FrameLength)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dInREQ,
   output logic                 dInACK,
   input  logic [bit_width-1:0] dIN,
   output logic                 dOutREQ,
   input  logic                 dOutACK,
`ifdef REQ_ACK_ACC_FRAMECNT_EN
   output logic [15:0]          dOutFrame,
`endif
   output logic [AccWidth-1:0]  dOUT
);

   localparam int CntWidth = $clog2(FrameLength) + 1;

   localparam logic [0:0] S_ACCUM = 1'b0;
   localparam logic [0:0] S_HOLD  = 1'b1;

   logic [0:0]          r_state;
   logic [0:0]          w_next_state;
   logic [AccWidth-1:0] r_acc;
   logic [AccWidth-1:0] r_dout;
   logic [CntWidth-1:0] r_word_cnt;
   logic [AccWidth-1:0] w_sum;
   logic                w_in_xfer;
   logic                w_last;

   assign w_in_xfer = dInREQ && dInACK;
   assign w_last    = (r_word_cnt == CntWidth'(FrameLength - 1));
   assign w_sum     = r_acc + AccWidth'(dIN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_ACCUM;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_ACCUM: if (w_in_xfer && w_last) w_next_state = S_HOLD;
         S_HOLD:  if (dOutACK)             w_next_state = S_ACCUM;
         default:                          w_next_state = S_ACCUM;
      endcase
   end

   always_comb begin
      dInACK  = 1'b0;
      dOutREQ = 1'b0;
      case (r_state)
         S_ACCUM: dInACK  = 1'b1;
         S_HOLD:  dOutREQ = 1'b1;
         default: dInACK  = 1'b0;
      endcase
   end

   // The final word bypasses r_acc so the total is ready the cycle HOLD begins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc      <= '0;
         r_dout     <= '0;
         r_word_cnt <= '0;
      end else if (w_in_xfer) begin
         if (w_last) begin
            r_dout     <= w_sum;
            r_acc      <= '0;
            r_word_cnt <= '0;
         end else begin
            r_acc      <= w_sum;
            r_word_cnt <= r_word_cnt + CntWidth'(1);
         end
      end
   end

   assign dOUT = r_dout;

`ifdef REQ_ACK_ACC_FRAMECNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (w_in_xfer && w_last) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end

   assign dOutFrame = r_frame_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_ack_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_ack_accumulator
// Purpose  : Directed scoreboard bench for req_ack_accumulator (5-bit, 4 words).
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_ack_accumulator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       dInREQ = 1'b0;
   logic       dInACK;
   logic [4:0] dIN = '0;
   logic       dOutREQ;
   logic       dOutACK = 1'b0;
   logic [6:0] dOUT;
`ifdef REQ_ACK_ACC_FRAMECNT_EN
   logic [15:0] dOutFrame;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];
   int cur_exp = 0;
   logic prev_req = 1'b0;

   req_ack_accumulator #(.bit_width(5), .FrameLength(4)) dut (
      .clk(clk), .rst(rst),
      .dInREQ(dInREQ), .dInACK(dInACK), .dIN(dIN),
      .dOutREQ(dOutREQ), .dOutACK(dOutACK),
`ifdef REQ_ACK_ACC_FRAMECNT_EN
      .dOutFrame(dOutFrame),
`endif
      .dOUT(dOUT)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: a new frame total is compared when dOutREQ rises, then must stay put.
   always @(negedge clk) begin
      if (rst) begin
         prev_req = 1'b0;
      end else begin
         if (dOutREQ && !prev_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 1, 0);
            end else begin
               cur_exp = exp_q.pop_front();
               check("frame_total", int'(dOUT), cur_exp);
            end
         end else if (dOutREQ && prev_req) begin
            check("held_total", int'(dOUT), cur_exp);
         end
         prev_req = dOutREQ;
      end
   end

   task automatic send(input int v);
      int t = 0;
      @(negedge clk);
      while (!dInACK && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!dInACK) check("send_timeout", 0, 1);
      dInREQ = 1'b1;
      dIN    = 5'(v);
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int a, input int b, input int c, input int d);
      exp_q.push_back(a + b + c + d);
      send(a); send(b); send(c); send(d);
      dInREQ = 1'b0;
   endtask

   task automatic wait_hold();
      int t = 0;
      @(negedge clk);
      while (!dOutREQ && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("hold_reached", int'(dOutREQ), 1);
   endtask

   task automatic ack();
      @(negedge clk);
      dOutACK = 1'b1;
      @(posedge clk);
      #1;
      dOutACK = 1'b0;
      @(negedge clk);
      check("ack_req_low", int'(dOutREQ), 0);
      check("ack_inack_high", int'(dInACK), 1);
   endtask

   task automatic mid_cycle_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_outreq", int'(dOutREQ), 0);
      check("rst_dout", int'(dOUT), 0);
      check("rst_inack", int'(dInACK), 1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset_outreq", int'(dOutREQ), 0);
      check("reset_dout", int'(dOUT), 0);
      check("reset_inack", int'(dInACK), 1);

      // 1,2,3,4 back to back, downstream stalled; inputs must be refused in HOLD.
      send_frame(1, 2, 3, 4);
      @(negedge clk);
      check("hold_inack", int'(dInACK), 0);
      check("hold_outreq", int'(dOutREQ), 1);
      dInREQ = 1'b1;
      dIN    = 5'd9;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle_outreq", int'(dOutREQ), 1);
         check("idle_inack", int'(dInACK), 0);
      end
      dInREQ = 1'b0;
      ack();

      send_frame(5, 5, 5, 5);
      wait_hold();
      ack();

      // Maximum words: total fits without overflow.
      send_frame(31, 31, 31, 31);
      wait_hold();
      mid_cycle_reset();

      // Gapped input: only real transfers accumulate.
      exp_q.push_back(10);
      send(1); dInREQ = 1'b0; @(posedge clk); #1;
      send(2); dInREQ = 1'b0; @(posedge clk); #1;
      send(3); dInREQ = 1'b0; @(posedge clk); #1;
      send(4); dInREQ = 1'b0;
      wait_hold();
      ack();

      // Partial frame discarded by reset.
      send(7); send(7);
      dInREQ = 1'b0;
      mid_cycle_reset();
      send_frame(1, 1, 1, 1);
      wait_hold();
      ack();

`ifdef REQ_ACK_ACC_FRAMECNT_EN
      mid_cycle_reset();
      check("framecnt_reset", int'(dOutFrame), 0);
      send_frame(2, 2, 2, 2);
      wait_hold();
      check("framecnt_1", int'(dOutFrame), 1);
      ack();
      send_frame(3, 3, 3, 3);
      wait_hold();
      check("framecnt_2", int'(dOutFrame), 2);
      ack();
      @(negedge clk);
      force dut.r_frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frame_cnt;
      send_frame(4, 4, 4, 4);
      wait_hold();
      check("framecnt_wrap", int'(dOutFrame), 0);
      ack();
`endif

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
